conv_seq_ctrl: RTL and testbench
================================

Name: conv_seq_ctrl

Overview:
Sequencer for a single-MAC 1-D convolution datapath. The datapath is an x sample memory, a filter coefficient ROM, and a saturating accumulator; both memories have a 1-cycle registered read.
- Loads LENX samples over a valid/ready slave port.
- Schedules LENX-LENF+1 dot products of LENF taps each.
- Drives memory/ROM addresses and accumulator clear/enable.
- Presents each result over a valid/ready master port.
- Sits between the input stream, the x memory/f ROM/accumulator, and the output stream. Replaces the ad-hoc read/write control logic.

Parameters:
LENX, 20, number of x samples per frame
LENF, 13, number of filter taps
ADDRX, 5, x memory address width (≥ clog2(LENX))
ADDRF, 4, f ROM address width (≥ clog2(LENF))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
s_valid_x  in  1  input sample valid
s_ready_x  out  1  controller accepts a sample
wr_en_x  out  1  x memory write enable (= s_valid_x & s_ready_x)
addr_x  out  ADDRX  x memory address (write address in LOAD, read address otherwise)
addr_f  out  ADDRF  f ROM address
clr_acc  out  1  accumulator synchronous clear
en_acc  out  1  accumulator add enable (product of current memory outputs)
m_valid_y  out  1  accumulator result valid
m_ready_y  in  1  downstream accepts result
frame_done  out  1  one-cycle pulse on the last output handshake of a frame

Behaviour:
- States: LOAD, COMPUTE, DRAIN, OUT. Counters:
  - wcnt (0..LENX-1)
  - k, the tap (0..LENF-1)
  - n, the output index (0..LENX-LENF)
- Reset (async, any state, mid-frame included):
  - state=LOAD; wcnt=k=n=0.
  - m_valid_y=0, clr_acc=0, en_acc=0, frame_done=0.
  - s_ready_x=0 while reset is high.
  - Any partially loaded frame is discarded.
- LOAD:
  - s_ready_x=1.
  - addr_x=wcnt, addr_f=0.
  - Each cycle with s_valid_x=1 writes the sample and increments wcnt.
  - On the write with wcnt=LENX-1: wcnt←0, n←0, k←0, go COMPUTE.
  - s_valid_x with s_ready_x=0 is ignored; no write.
- COMPUTE (LENF cycles per output):
  - addr_x=n+k, addr_f=k, s_ready_x=0; k increments each cycle.
  - clr_acc=1 combinationally in the k=0 cycle only.
  - en_acc is registered: high exactly LENF cycles, one cycle after each address issue, aligned to the memory read latency.
  - After issuing k=LENF-1: k←0, go DRAIN.
- DRAIN (1 cycle):
  - en_acc=1 for the last tap; no address issued (addr_x/addr_f hold their last value).
  - Next state OUT; m_valid_y←1 registered.
- OUT:
  - m_valid_y=1 and en_acc=0; the accumulator holds its value.
  - When m_valid_y & m_ready_y: m_valid_y←0.
    - If n<LENX-LENF: n←n+1, go COMPUTE.
    - Else: frame_done=1 that cycle, n←0, go LOAD.
- m_valid_y never drops without a handshake.
- m_ready_y outside OUT has no effect.
- Latency from the first COMPUTE cycle to m_valid_y=1: LENF+1 cycles.
- Minimum output period with m_ready_y held high: LENF+2 cycles.
- The first sample of the next frame can be accepted in the cycle after frame_done.
- n+k never exceeds LENX-1; no wrap-around of addr_x.
- clr_acc and en_acc are never both high.
- wr_en_x is high only in LOAD.
- Counters are sized to their parameter ranges. Addresses are zero-extended to the port width.

Test Plan:
1. Reset then stream 20 samples with s_valid_x held high → s_ready_x high for 20 cycles; addr_x 0..19; COMPUTE entered the cycle after the 20th write.
2. m_ready_y held high → 8 results; each m_valid_y pulse is 1 cycle; 15-cycle period; addr_x runs n..n+12 with addr_f 0..12; frame_done on the 8th handshake.
3. m_ready_y low for 7 cycles in OUT with n=3 → m_valid_y stays 1 with no accumulator update; handshake on the 8th cycle moves to n=4.
4. s_valid_x toggled randomly (50%) → exactly 20 writes at addresses 0..19 in order; no write while s_ready_x=0.
5. Assert reset during COMPUTE at n=5, k=6 → all outputs at their reset values immediately (async); after release, s_ready_x=1 and wcnt=0.
6. Back-to-back frames with ideal consumer → second frame's first write occurs the cycle after frame_done; outputs match the golden convolution model (saturating accumulator) for 2 frames.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer for a single-MAC 1-D convolution datapath.
// Loads one frame of x samples, sweeps LENF-tap dot products over it and hands each result downstream.
module conv_seq_ctrl #(
    parameter int LENX  = 20,
    parameter int LENF  = 13,
    parameter int ADDRX = 5,
    parameter int ADDRF = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid_x,
    output logic             s_ready_x,
    output logic             wr_en_x,
    output logic [ADDRX-1:0] addr_x,
    output logic [ADDRF-1:0] addr_f,
    output logic             clr_acc,
    output logic             en_acc,
    output logic             m_valid_y,
    input  logic             m_ready_y,
    output logic             frame_done
);

    localparam int NOUT = LENX - LENF + 1;
    localparam int WCW  = (LENX > 1) ? $clog2(LENX) : 1;
    localparam int KW   = (LENF > 1) ? $clog2(LENF) : 1;
    localparam int NW   = (NOUT > 1) ? $clog2(NOUT) : 1;

    localparam logic [WCW-1:0]   W_LAST = WCW'(LENX - 1);
    localparam logic [KW-1:0]    K_LAST = KW'(LENF - 1);
    localparam logic [NW-1:0]    N_LAST = NW'(LENX - LENF);
    localparam logic [ADDRX-1:0] X_TAIL = ADDRX'(LENF - 1);
    localparam logic [ADDRF-1:0] F_LAST = ADDRF'(LENF - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_OUT
    } state_e;

    state_e         state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [KW-1:0]  k_q, k_d;
    logic [NW-1:0]  n_q, n_d;
    logic           en_acc_q, en_acc_d;
    logic           m_valid_q, m_valid_d;

    logic           wr_fire;
    logic           out_fire;

    assign wr_fire  = (state_q == S_LOAD) && s_valid_x && !reset;
    assign out_fire = (state_q == S_OUT) && m_valid_q && m_ready_y;

    // State and counter registers; a reset mid-frame discards whatever was loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_LOAD;
            wcnt_q    <= '0;
            k_q       <= '0;
            n_q       <= '0;
            en_acc_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            k_q       <= k_d;
            n_q       <= n_d;
            en_acc_q  <= en_acc_d;
            m_valid_q <= m_valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        k_d       = k_q;
        n_d       = n_q;
        m_valid_d = m_valid_q;
        // Memories have a one-cycle read, so the add enable trails each address issue by one cycle.
        en_acc_d  = (state_q == S_COMPUTE);

        case (state_q)
            S_LOAD: begin
                if (wr_fire) begin
                    if (wcnt_q == W_LAST) begin
                        wcnt_d  = '0;
                        k_d     = '0;
                        n_d     = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        wcnt_d = wcnt_q + WCW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DRAIN: begin
                m_valid_d = 1'b1;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (out_fire) begin
                    m_valid_d = 1'b0;
                    if (n_q == N_LAST) begin
                        n_d     = '0;
                        state_d = S_LOAD;
                    end else begin
                        n_d     = n_q + NW'(1);
                        state_d = S_COMPUTE;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        s_ready_x  = (state_q == S_LOAD) && !reset;
        wr_en_x    = s_valid_x && s_ready_x;
        addr_x     = '0;
        addr_f     = '0;
        clr_acc    = 1'b0;
        en_acc     = en_acc_q;
        m_valid_y  = m_valid_q;
        frame_done = out_fire && (n_q == N_LAST);

        case (state_q)
            S_LOAD: begin
                addr_x = ADDRX'(wcnt_q);
            end
            S_COMPUTE: begin
                addr_x  = ADDRX'(n_q) + ADDRX'(k_q);
                addr_f  = ADDRF'(k_q);
                clr_acc = (k_q == '0);
            end
            default: begin
                // No new read after the last tap: keep the final tap's addresses on the bus.
                addr_x = ADDRX'(n_q) + X_TAIL;
                addr_f = F_LAST;
            end
        endcase
    end

    a_clr_en_exclusive : assert property (@(posedge clk) disable iff (reset)
        !(clr_acc && en_acc));
    a_write_only_in_load : assert property (@(posedge clk) disable iff (reset)
        wr_en_x |-> (state_q == S_LOAD));
    a_valid_held : assert property (@(posedge clk) disable iff (reset)
        (m_valid_y && !m_ready_y) |=> m_valid_y);
    a_addr_in_range : assert property (@(posedge clk) disable iff (reset)
        int'(addr_x) < LENX);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: a behavioural x memory / coefficient ROM / saturating accumulator around the
// sequencer, a stimulus side that pushes expected results into a scoreboard, and a monitor that pops them.
module tb_conv_seq_ctrl;

    localparam int LENX  = 20;
    localparam int LENF  = 13;
    localparam int ADDRX = 5;
    localparam int ADDRF = 4;
    localparam int NOUT  = LENX - LENF + 1;
    localparam int NFR   = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             s_valid_x = 1'b0;
    logic             s_ready_x;
    logic             wr_en_x;
    logic [ADDRX-1:0] addr_x;
    logic [ADDRF-1:0] addr_f;
    logic             clr_acc;
    logic             en_acc;
    logic             m_valid_y;
    logic             m_ready_y = 1'b1;
    logic             frame_done;

    conv_seq_ctrl #(.LENX(LENX), .LENF(LENF), .ADDRX(ADDRX), .ADDRF(ADDRF)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid_x  (s_valid_x),
        .s_ready_x  (s_ready_x),
        .wr_en_x    (wr_en_x),
        .addr_x     (addr_x),
        .addr_f     (addr_f),
        .clr_acc    (clr_acc),
        .en_acc     (en_acc),
        .m_valid_y  (m_valid_y),
        .m_ready_y  (m_ready_y),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL timeout %s: condition not reached within cycle budget", nm);
    endtask

    // Frame data and coefficients
    int xf [NFR][LENX];
    int fco[LENF];

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int golden(input int f, input int n);
        int a;
        a = 0;
        for (int k = 0; k < LENF; k++) a = sat16(a + xf[f][n+k] * fco[k]);
        return a;
    endfunction

    // Frames 0, 1 and 4 are hand-derived: x=i with f=9(k+1) gives 9*(91n+728); x=+127 / -128 saturates.
    function automatic int expected(input int f, input int n);
        case (f)
            0:       return 819 * n + 6552;
            1:       return 32767;
            4:       return -32768;
            default: return golden(f, n);
        endcase
    endfunction

    // Behavioural datapath
    logic signed [7:0]  xmem[32];
    logic signed [7:0]  from[16];
    logic signed [7:0]  xq, fq;
    logic signed [15:0] acc = '0;
    logic signed [7:0]  s_data = '0;

    always @(posedge clk) begin
        if (wr_en_x) xmem[addr_x] <= s_data;
        xq <= xmem[addr_x];
        fq <= from[addr_f];
        if (clr_acc) acc <= '0;
        else if (en_acc) acc <= 16'(sat16(int'(acc) + int'(xq) * int'(fq)));
    end

    typedef struct {
        int y;
        bit last;
        bit chkp;
    } exp_t;

    exp_t sbq[$];

    int widx = 0;
    int fidx = 0;
    int cfid = 0;
    int exp_n = 0;
    bit drv_en = 1'b0;

    // Sample source: always valid, except frame 2 which toggles valid at random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            s_valid_x = drv_en && (fidx < NFR) && ((fidx == 2) ? ($urandom_range(0, 1) == 1) : 1'b1);
            s_data    = (fidx < NFR) ? 8'(xf[fidx][widx]) : 8'sd0;
        end
    end

    // Result sink: ideal, except a 7-cycle stall on output n=3 of frame 1.
    int stall_cnt = 0;
    bit stall_done = 1'b0;
    int acc_hold = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!stall_done && (stall_cnt > 0 || (cfid == 1 && exp_n == 3 && m_valid_y && !reset))) begin
                if (stall_cnt == 0) begin
                    acc_hold = int'(acc);
                end else begin
                    chk("stall_valid_held", int'(m_valid_y), 1);
                    chk("stall_acc_held", int'(acc), acc_hold);
                    chk("stall_en_acc", int'(en_acc), 0);
                end
                if (stall_cnt < 7) begin
                    m_ready_y = 1'b0;
                    stall_cnt++;
                end else begin
                    m_ready_y  = 1'b1;
                    stall_done = 1'b1;
                end
            end else begin
                m_ready_y = 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    int   cyc = 0;
    bit   active = 1'b0;
    int   kk = 0;
    bit   prev_active = 1'b0;
    bit   exp_mv = 1'b0;
    int   last_hs = 0;
    bit   last_hs_ok = 1'b0;
    bit   nextclr = 1'b0;
    bit   nextwr = 1'b0;
    bit   hs, act_now, drain_now;
    int   fd_exp;
    exp_t it;
    exp_t e;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            sbq.delete();
            widx        = 0;
            cfid        = fidx;
            exp_n       = 0;
            active      = 1'b0;
            kk          = 0;
            prev_active = 1'b0;
            exp_mv      = 1'b0;
            last_hs_ok  = 1'b0;
            nextclr     = 1'b0;
            nextwr      = 1'b0;
        end else begin
            hs = m_valid_y && m_ready_y;
            chk("wr_en_x", int'(wr_en_x), int'(s_valid_x && s_ready_x));
            chk("clr_en_exclusive", int'(clr_acc && en_acc), 0);
            if (nextclr) chk("compute_start_clr", int'(clr_acc), 1);
            nextclr = 1'b0;
            if (nextwr) begin
                chk("b2b_first_write_en", int'(wr_en_x), 1);
                chk("b2b_first_write_addr", int'(addr_x), 0);
            end
            nextwr = 1'b0;

            if (wr_en_x) begin
                chk("wr_addr", int'(addr_x), widx);
                if (widx == 0) begin
                    for (int n = 0; n < NOUT; n++) begin
                        e.y    = expected(fidx, n);
                        e.last = (n == NOUT - 1);
                        e.chkp = (fidx != 1);
                        sbq.push_back(e);
                    end
                end
                widx++;
                if (widx == LENX) begin
                    widx    = 0;
                    fidx++;
                    nextclr = 1'b1;
                end
            end

            if (clr_acc) begin
                active = 1'b1;
                kk     = 0;
            end
            act_now = active;
            if (active) begin
                chk("sweep_addr_x", int'(addr_x), exp_n + kk);
                chk("sweep_addr_f", int'(addr_f), kk);
                kk++;
                if (kk == LENF) active = 1'b0;
            end
            chk("en_acc", int'(en_acc), int'(prev_active));
            drain_now   = prev_active && !act_now;
            prev_active = act_now;

            chk("m_valid_y", int'(m_valid_y), int'(exp_mv));
            fd_exp = 0;
            if (hs) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_result: got %0d expected no output", int'(acc));
                end else begin
                    it = sbq.pop_front();
                    chk("result_y", int'(acc), it.y);
                    fd_exp = int'(it.last);
                    if (last_hs_ok && it.chkp) chk("output_period", cyc - last_hs, LENF + 2);
                    if (it.last) begin
                        exp_n      = 0;
                        cfid++;
                        last_hs_ok = 1'b0;
                        if (cfid == 1) nextwr = 1'b1;
                    end else begin
                        exp_n++;
                        last_hs_ok = it.chkp;
                        last_hs    = cyc;
                    end
                end
            end
            chk("frame_done", int'(frame_done), fd_exp);
            exp_mv = drain_now ? 1'b1 : (hs ? 1'b0 : exp_mv);
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready_x"}, int'(s_ready_x), 0);
        chk({tag, "_wr_en_x"}, int'(wr_en_x), 0);
        chk({tag, "_m_valid_y"}, int'(m_valid_y), 0);
        chk({tag, "_clr_acc"}, int'(clr_acc), 0);
        chk({tag, "_en_acc"}, int'(en_acc), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_addr_x"}, int'(addr_x), 0);
        chk({tag, "_addr_f"}, int'(addr_f), 0);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < LENX; i++) begin
            xf[0][i] = i;
            xf[1][i] = 127;
            xf[2][i] = (i % 2 == 1) ? (120 - 5 * i) : (-100 + 7 * i);
            xf[3][i] = (i % 3 == 0) ? 127 : (-60 - i);
            xf[4][i] = -128;
        end
        for (int k = 0; k < 16; k++) from[k] = '0;
        for (int k = 0; k < LENF; k++) begin
            fco[k]  = 9 * (k + 1);
            from[k] = 8'(fco[k]);
        end

        reset = 1'b1;
        #3;
        chk_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("release_s_ready_x", int'(s_ready_x), 1);
        chk("release_addr_x", int'(addr_x), 0);
        drv_en = 1'b1;

        // Frames 0..2 run to completion, frame 3 is loaded.
        cnt = 0;
        while (fidx < 4 && cnt < 4000) begin
            @(posedge clk);
            #2;
            cnt++;
        end
        if (fidx < 4) tmo("frames_0_to_3_loaded");
        drv_en = 1'b0;

        // Abort frame 3 in the middle of output n=5, tap k=6.
        cnt = 0;
        while (!(cfid == 3 && exp_n == 5 && int'(addr_f) == 6) && cnt < 1000) begin
            @(posedge clk);
            #2;
            cnt++;
        end
        if (!(cfid == 3 && exp_n == 5 && int'(addr_f) == 6)) tmo("frame3_n5_k6");
        chk("pre_reset_addr_x", int'(addr_x), 11);
        #1 reset = 1'b1;
        #1;
        chk_reset_outputs("async");
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rerelease_s_ready_x", int'(s_ready_x), 1);
        chk("rerelease_wcnt_addr_x", int'(addr_x), 0);
        chk("rerelease_m_valid_y", int'(m_valid_y), 0);
        drv_en = 1'b1;

        cnt = 0;
        while (cfid < 5 && cnt < 2000) begin
            @(posedge clk);
            #2;
            cnt++;
        end
        if (cfid < 5) tmo("frame4_done");
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_empty", sbq.size(), 0);
        chk("stall_exercised", int'(stall_done), 1);
        chk("frames_loaded", fidx, NFR);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
